// File: rtl/bsg_wormhole_router_output_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bsg_wormhole_router_output_arbiter                            |
// | Brief    : Per-output round-robin arbiter with wormhole lock and yumi.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bsg_wormhole_router_output_arbiter #(
   parameter int input_dirs_p = 3
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [input_dirs_p-1:0] reqs_i,
   input  logic [input_dirs_p-1:0] release_i,
   input  logic [input_dirs_p-1:0] valids_i,
   input  logic                    ready_i,
   output logic                    valid_o,
   output logic [input_dirs_p-1:0] data_sel_o,
   output logic [input_dirs_p-1:0] yumis_o,
   output logic                    locked_o
);

   localparam logic [input_dirs_p-1:0] c_one       = {{(input_dirs_p-1){1'b0}}, 1'b1};
   localparam logic [input_dirs_p-1:0] c_last_init = c_one << (input_dirs_p-1);

   logic [input_dirs_p-1:0] r_grants;
   logic [input_dirs_p-1:0] r_last;
   logic [input_dirs_p-1:0] w_mask;
   logic [input_dirs_p-1:0] w_hi_reqs;
   logic [input_dirs_p-1:0] w_gnt;
   logic [input_dirs_p-1:0] w_sel;
   logic                    w_lock;
   logic                    w_hs;

   // The lock only bites while the owning input still has payload in flight,
   // so a release in the same cycle frees the output without a bubble.
   assign w_lock = |(r_grants & ~release_i);

   // w_mask marks every position strictly above the last winner.
   always_comb begin
      w_mask = '0;
      for (int i = 1; i < input_dirs_p; i++) begin
         w_mask[i] = w_mask[i-1] | r_last[i-1];
      end
   end

   // Lowest request above the last winner, otherwise wrap to lowest overall.
   assign w_hi_reqs = reqs_i & w_mask;
   assign w_gnt     = (|w_hi_reqs) ? (w_hi_reqs & (~w_hi_reqs + c_one))
                                   : (reqs_i & (~reqs_i + c_one));

   assign w_sel      = w_lock ? r_grants : w_gnt;
   assign data_sel_o = w_sel;
   assign valid_o    = |(w_sel & valids_i);
   assign w_hs       = valid_o & ready_i;
   assign yumis_o    = w_hs ? w_sel : '0;
   assign locked_o   = w_lock;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_grants <= '0;
         r_last   <= c_last_init;
      end else if (w_hs) begin
         r_grants <= w_sel;
         if (!w_lock) begin
            r_last <= w_gnt;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert ($onehot0(yumis_o));
         assert ($onehot0(r_grants));
         assert (!(w_lock && |(r_grants & ~release_i & valids_i & reqs_i)));
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bsg_wormhole_router_output_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bsg_wormhole_router_output_arbiter                         |
// | Brief    : Randomized bench with an index-based arbitration model.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bsg_wormhole_router_output_arbiter;

   localparam int N = 3;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic [N-1:0] reqs_i;
   logic [N-1:0] release_i;
   logic [N-1:0] valids_i;
   logic         ready_i;
   wire          valid_o;
   wire  [N-1:0] data_sel_o;
   wire  [N-1:0] yumis_o;
   wire          locked_o;

   bsg_wormhole_router_output_arbiter #(.input_dirs_p(N)) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .reqs_i     (reqs_i),
      .release_i  (release_i),
      .valids_i   (valids_i),
      .ready_i    (ready_i),
      .valid_o    (valid_o),
      .data_sel_o (data_sel_o),
      .yumis_o    (yumis_o),
      .locked_o   (locked_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Upstream input-port model: one packet per input, header then len payload flits.
   bit has_pkt  [N];
   bit hdr_sent [N];
   bit gen_en   [N];
   int rem      [N];
   int len      [N];

   // Arbiter reference: owner index and last newly granted index.
   int owner;
   int last;

   int pkt_pct;
   int pay_valid_pct;
   int ready_pct;
   int max_len;

   logic [N-1:0] obs_yumi;
   logic         obs_locked;

   task automatic new_pkt(input int i, input int l);
      has_pkt[i]  = 1'b1;
      hdr_sent[i] = 1'b0;
      len[i]      = l;
      rem[i]      = 0;
   endtask

   task automatic model_reset();
      owner = -1;
      last  = N - 1;
      for (int i = 0; i < N; i++) begin
         has_pkt[i]  = 1'b0;
         hdr_sent[i] = 1'b0;
         rem[i]      = 0;
         len[i]      = 0;
      end
   endtask

   task automatic step();
      bit           lockv;
      bit           found;
      int           sel_idx;
      int           idx;
      bit           exp_valid;
      bit           hs;
      logic [N-1:0] exp_sel;
      logic [N-1:0] exp_yumi;
      @(negedge clk_i);
      reset_i = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!has_pkt[i] && gen_en[i] && ($urandom_range(99) < pkt_pct))
            new_pkt(i, $urandom_range(max_len));
         reqs_i[i]    = has_pkt[i] && !hdr_sent[i];
         release_i[i] = (rem[i] == 0);
         valids_i[i]  = has_pkt[i] && (!hdr_sent[i] || ($urandom_range(99) < pay_valid_pct));
      end
      ready_i = ($urandom_range(99) < ready_pct);
      #1;
      lockv   = (owner >= 0) && !release_i[owner];
      sel_idx = -1;
      if (lockv) begin
         sel_idx = owner;
      end else begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            idx = (last + k) % N;
            if (!found && reqs_i[idx]) begin
               sel_idx = idx;
               found   = 1'b1;
            end
         end
      end
      exp_sel   = (sel_idx >= 0) ? (N'(1) << sel_idx) : '0;
      exp_valid = (sel_idx >= 0) && valids_i[sel_idx];
      hs        = exp_valid && ready_i;
      exp_yumi  = hs ? exp_sel : '0;
      check_val("data_sel", 32'(data_sel_o), 32'(exp_sel));
      check_val("valid",    32'(valid_o),    32'(exp_valid));
      check_val("yumis",    32'(yumis_o),    32'(exp_yumi));
      check_val("locked",   32'(locked_o),   32'(lockv));
      obs_yumi   = yumis_o;
      obs_locked = locked_o;
      @(posedge clk_i);
      if (hs) begin
         owner = sel_idx;
         if (!lockv) last = sel_idx;
         if (!hdr_sent[sel_idx]) begin
            rem[sel_idx] = len[sel_idx];
            if (len[sel_idx] == 0) has_pkt[sel_idx] = 1'b0;
            else                   hdr_sent[sel_idx] = 1'b1;
         end else begin
            rem[sel_idx]--;
            if (rem[sel_idx] == 0) begin
               has_pkt[sel_idx]  = 1'b0;
               hdr_sent[sel_idx] = 1'b0;
            end
         end
      end
   endtask

   // Router reset also resets the upstream input controls.
   task automatic do_reset(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk_i);
         reset_i   = 1'b1;
         reqs_i    = '0;
         valids_i  = '0;
         release_i = '1;
         ready_i   = 1'($urandom_range(1));
         #1;
         if (c > 0) begin
            check_val("rst_valid",  32'(valid_o),    32'(0));
            check_val("rst_sel",    32'(data_sel_o), 32'(0));
            check_val("rst_yumis",  32'(yumis_o),    32'(0));
            check_val("rst_locked", 32'(locked_o),   32'(0));
         end
         @(posedge clk_i);
      end
      model_reset();
   endtask

   task automatic set_knobs(input int pp, input int pv, input int rp, input int ml);
      pkt_pct       = pp;
      pay_valid_pct = pv;
      ready_pct     = rp;
      max_len       = ml;
   endtask

   initial begin
      reset_i   = 1'b1;
      reqs_i    = '0;
      release_i = '1;
      valids_i  = '0;
      ready_i   = 1'b0;
      for (int i = 0; i < N; i++) gen_en[i] = 1'b1;
      model_reset();

      // Idle after reset
      do_reset(2);
      set_knobs(0, 100, 100, 0);
      for (int c = 0; c < 3; c++) step();

      // Two-flit packet on input 0 locks out input 1
      do_reset(1);
      new_pkt(0, 1);
      new_pkt(1, 0);
      step(); check_val("lk_y0", 32'(obs_yumi), 32'(3'b001));
      step(); check_val("lk_y1", 32'(obs_yumi), 32'(3'b001));
      check_val("lk_l1", 32'(obs_locked), 32'(1));
      step(); check_val("lk_y2", 32'(obs_yumi), 32'(3'b010));

      // Round robin over single-flit packets
      do_reset(1);
      set_knobs(100, 100, 100, 0);
      step(); check_val("rr0", 32'(obs_yumi), 32'(3'b001));
      step(); check_val("rr1", 32'(obs_yumi), 32'(3'b010));
      step(); check_val("rr2", 32'(obs_yumi), 32'(3'b100));
      step(); check_val("rr3", 32'(obs_yumi), 32'(3'b001));
      gen_en[1]  = 1'b0;
      has_pkt[1] = 1'b0;
      step(); check_val("rr4", 32'(obs_yumi), 32'(3'b100));
      step(); check_val("rr5", 32'(obs_yumi), 32'(3'b001));
      gen_en[1]  = 1'b1;

      // Backpressure mid-packet on input 1
      do_reset(1);
      set_knobs(0, 100, 100, 0);
      new_pkt(1, 3);
      step(); check_val("bp_hdr", 32'(obs_yumi), 32'(3'b010));
      ready_pct = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         check_val("bp_y", 32'(obs_yumi), 32'(0));
         check_val("bp_l", 32'(obs_locked), 32'(1));
      end
      ready_pct = 100;
      step(); check_val("bp_res", 32'(obs_yumi), 32'(3'b010));

      // Bubble inside input 2's packet while input 0 requests
      do_reset(1);
      new_pkt(2, 2);
      step(); check_val("bb_hdr", 32'(obs_yumi), 32'(3'b100));
      new_pkt(0, 0);
      pay_valid_pct = 0;
      for (int c = 0; c < 2; c++) begin
         step();
         check_val("bb_y", 32'(obs_yumi), 32'(0));
         check_val("bb_l", 32'(obs_locked), 32'(1));
      end
      pay_valid_pct = 100;
      step(); check_val("bb_res", 32'(obs_yumi), 32'(3'b100));

      // Reset while input 1 owns the output
      do_reset(1);
      new_pkt(1, 3);
      step(); check_val("rm_hdr", 32'(obs_yumi), 32'(3'b010));
      step();
      do_reset(1);
      new_pkt(0, 0);
      new_pkt(1, 0);
      step();
      check_val("rm_l", 32'(obs_locked), 32'(0));
      check_val("rm_y", 32'(obs_yumi), 32'(3'b001));

      // Randomized traffic with occasional resets
      for (int seg = 0; seg < 10; seg++) begin
         set_knobs($urandom_range(10, 100), $urandom_range(30, 100),
                   $urandom_range(20, 100), $urandom_range(0, 4));
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(199) == 0) do_reset(1);
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
